hazard_fwd_unit: RTL and testbench

// Parametrised data-hazard and forwarding unit for the RV32 pipelines; generalises the fixed two-source hazard/forwarding pair.

---
 rtl/hazard_fwd_unit_pkg.sv | 9 +
 rtl/hazard_fwd_unit_fwd_port_mux.sv | 40 ++++
 rtl/hazard_fwd_unit.sv | 74 +++++++
 tb/tb_hazard_fwd_unit.sv | 154 +++++++++++++++
 4 files changed

// File: rtl/hazard_fwd_unit_pkg.sv
// hazard_fwd_unit_pkg: shared constants and helpers for the hazard/forwarding unit
package hazard_fwd_unit_pkg;
   localparam int X0 = 0;
   localparam int CNT_W = 32;
   typedef logic [CNT_W-1:0] cnt_t;
   function automatic cnt_t sat_inc(input cnt_t c);
      return (c == '1) ? c : c + cnt_t'(1);
   endfunction
endpackage

// File: rtl/hazard_fwd_unit_fwd_port_mux.sv
// hazard_fwd_unit_fwd_port_mux: per-read-port youngest-match forwarding with write-back bypass
module hazard_fwd_unit_fwd_port_mux
   import hazard_fwd_unit_pkg::*;
#(
   parameter int XLEN = 32,
   parameter int AW = 5,
   parameter int NSTAGE = 2,
   parameter int LOAD_STG = 1
) (
   input  logic [AW-1:0]          addr,
   input  logic [XLEN-1:0]        rf_data,
   input  logic [NSTAGE-1:0]      ent_v,
   input  logic [NSTAGE*AW-1:0]   ent_rd,
   input  logic [NSTAGE-1:0]      ent_ld,
   input  logic [NSTAGE*XLEN-1:0] stg_data,
   input  logic                   wb_we,
   input  logic [AW-1:0]          wb_addr,
   input  logic [XLEN-1:0]        wb_data,
   output logic [XLEN-1:0]        op_data,
   output logic                   hazard
);
   logic            hit, hit_rdy, nz;
   logic [XLEN-1:0] hit_data;
   assign nz = addr != AW'(X0);
   // Walk oldest to youngest so the youngest match is the last one written
   always_comb begin
      hit = 1'b0;
      hit_rdy = 1'b0;
      hit_data = '0;
      for (int s = NSTAGE - 1; s >= 0; s--)
         if (ent_v[s] && ent_rd[s*AW +: AW] == addr && nz) begin
            hit = 1'b1;
            hit_rdy = !ent_ld[s] || s >= LOAD_STG;
            hit_data = stg_data[s*XLEN +: XLEN];
         end
   end
   assign hazard = hit & ~hit_rdy;
   assign op_data = hit ? hit_data
                  : (wb_we && wb_addr == addr && nz) ? wb_data : rf_data;
endmodule

// File: rtl/hazard_fwd_unit.sv
// hazard_fwd_unit: in-flight destination scoreboard, operand forwarding and stall generation
module hazard_fwd_unit
   import hazard_fwd_unit_pkg::*;
#(
   parameter int XLEN = 32,
   parameter int AW = 5,
   parameter int NREAD = 2,
   parameter int NSTAGE = 2,
   parameter int LOAD_STG = 1
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   id_valid,
   input  logic [NREAD*AW-1:0]    id_rs_addr,
   input  logic [NREAD*XLEN-1:0]  id_rs_data,
   input  logic [AW-1:0]          id_rd,
   input  logic                   id_regw,
   input  logic                   id_is_load,
   input  logic                   flush,
   input  logic                   mem_wait,
   input  logic [NSTAGE*XLEN-1:0] stg_data,
   input  logic                   wb_we,
   input  logic [AW-1:0]          wb_addr,
   input  logic [XLEN-1:0]        wb_data,
   output logic [NREAD*XLEN-1:0]  op_data,
   output logic                   stall,
   output logic [NSTAGE-1:0]      stg_valid,
   output logic [31:0]            stall_count
);
   logic [NSTAGE-1:0]    v, ld;
   logic [NSTAGE*AW-1:0] rd;
   logic [NREAD-1:0]     hazard;
   logic                 haz_stall;
   for (genvar p = 0; p < NREAD; p++) begin : g_port
      hazard_fwd_unit_fwd_port_mux #(
         .XLEN(XLEN), .AW(AW), .NSTAGE(NSTAGE), .LOAD_STG(LOAD_STG)
      ) u_mux (
         .addr(id_rs_addr[p*AW +: AW]),
         .rf_data(id_rs_data[p*XLEN +: XLEN]),
         .ent_v(v),
         .ent_rd(rd),
         .ent_ld(ld),
         .stg_data(stg_data),
         .wb_we(wb_we),
         .wb_addr(wb_addr),
         .wb_data(wb_data),
         .op_data(op_data[p*XLEN +: XLEN]),
         .hazard(hazard[p])
      );
   end
   assign haz_stall = id_valid & |hazard;
   assign stall = mem_wait | haz_stall;
   assign stg_valid = v;
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         v <= '0;
         ld <= '0;
         rd <= '0;
         stall_count <= '0;
      end else begin
         if (stall) stall_count <= sat_inc(stall_count);
         // A memory wait freezes everything, including a pending flush
         if (!mem_wait) begin
            for (int s = NSTAGE - 1; s > 0; s--) begin
               v[s] <= (s == 1 && flush) ? 1'b0 : v[s-1];
               ld[s] <= ld[s-1];
               rd[s*AW +: AW] <= rd[(s-1)*AW +: AW];
            end
            v[0] <= id_valid & id_regw & ~flush & ~haz_stall & (id_rd != AW'(X0));
            ld[0] <= id_is_load;
            rd[0 +: AW] <= id_rd;
         end
      end
endmodule

// File: tb/tb_hazard_fwd_unit.sv
// tb_hazard_fwd_unit: directed checks of forwarding, load-use stall, flush, mem_wait and reset
module tb_hazard_fwd_unit;
   logic        clk = 1'b0, rst = 1'b1;
   logic        id_valid = 0, id_regw = 0, id_is_load = 0, flush = 0, mem_wait = 0, wb_we = 0;
   logic [9:0]  id_rs_addr = '0;
   logic [63:0] id_rs_data = {32'h2222_2222, 32'h1111_1111};
   logic [4:0]  id_rd = '0, wb_addr = '0;
   logic [63:0] stg_data = {32'hB1B1_0001, 32'hA0A0_0000};
   logic [31:0] wb_data = '0;
   logic [63:0] op_data;
   logic        stall;
   logic [1:0]  stg_valid;
   logic [31:0] stall_count;
   int n_cmp = 0, n_err = 0;

   hazard_fwd_unit #(.XLEN(32), .AW(5), .NREAD(2), .NSTAGE(2), .LOAD_STG(1)) dut (
      .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs_addr(id_rs_addr),
      .id_rs_data(id_rs_data), .id_rd(id_rd), .id_regw(id_regw), .id_is_load(id_is_load),
      .flush(flush), .mem_wait(mem_wait), .stg_data(stg_data), .wb_we(wb_we),
      .wb_addr(wb_addr), .wb_data(wb_data), .op_data(op_data), .stall(stall),
      .stg_valid(stg_valid), .stall_count(stall_count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic issue(input logic val, input logic [4:0] rd, input logic load,
                        input logic [4:0] rs0, input logic [4:0] rs1);
      id_valid = val;
      id_regw = val;
      id_rd = rd;
      id_is_load = load;
      id_rs_addr = {rs1, rs0};
      #1;
   endtask

   task automatic drain();
      issue(0, 0, 0, 0, 0);
      tick();
      tick();
   endtask

   initial begin
      // reset state
      #2;
      chk("rst_valid", 32'(stg_valid), 0);
      chk("rst_count", stall_count, 0);
      chk("rst_stall", 32'(stall), 0);
      mem_wait = 1; #1;
      chk("rst_stall_memwait", 32'(stall), 1);
      mem_wait = 0;
      tick();
      rst = 0;
      // 1: add x5 ; add x6,x5
      issue(1, 5, 0, 1, 2);
      chk("t1_nomatch_op0", op_data[31:0], 32'h1111_1111);
      tick();
      chk("t1_valid", 32'(stg_valid), 2'b01);
      issue(1, 6, 0, 5, 0);
      chk("t1_fwd_s0", op_data[31:0], 32'hA0A0_0000);
      chk("t1_x0_port1", op_data[63:32], 32'h2222_2222);
      chk("t1_stall", 32'(stall), 0);
      tick();
      issue(0, 0, 0, 5, 6);
      chk("t1_fwd_s1", op_data[31:0], 32'hB1B1_0001);
      chk("t1_fwd_s0_p1", op_data[63:32], 32'hA0A0_0000);
      drain();
      // 3: x5 in both stages, youngest wins; x0 never tracked
      issue(1, 5, 0, 0, 0); tick();
      issue(1, 5, 0, 5, 0);
      chk("t3_both_match", op_data[31:0], 32'hA0A0_0000);
      tick();
      chk("t3_valid", 32'(stg_valid), 2'b11);
      issue(1, 0, 0, 5, 5);
      chk("t3_youngest", op_data[63:32], 32'hA0A0_0000);
      tick();
      chk("t3_x0_untracked", 32'(stg_valid), 2'b10);
      issue(0, 0, 0, 0, 5);
      chk("t3_x0_rf", op_data[31:0], 32'h1111_1111);
      chk("t3_s1_only", op_data[63:32], 32'hB1B1_0001);
      drain();
      // 2: lw x7 ; add x8,x7
      issue(1, 7, 1, 0, 0); tick();
      issue(1, 8, 0, 7, 3);
      chk("t2_stall", 32'(stall), 1);
      tick();
      chk("t2_bubble", 32'(stg_valid), 2'b10);
      chk("t2_count", stall_count, 1);
      chk("t2_stall_end", 32'(stall), 0);
      chk("t2_fwd_load", op_data[31:0], 32'hB1B1_0001);
      tick();
      chk("t2_count_hold", stall_count, 1);
      drain();
      // 4: write-back bypass
      wb_we = 1; wb_addr = 9; wb_data = 32'hDEAD_BEEF;
      issue(0, 0, 0, 4, 9);
      chk("t4_bypass", op_data[63:32], 32'hDEAD_BEEF);
      chk("t4_no_bypass", op_data[31:0], 32'h1111_1111);
      wb_we = 0; #1;
      chk("t4_we_off", op_data[63:32], 32'h2222_2222);
      // 5: flush kills stage-0 entry and current issue
      issue(1, 3, 0, 0, 0); tick();
      flush = 1;
      issue(1, 4, 0, 0, 0);
      tick();
      flush = 0;
      chk("t5_flush_valid", 32'(stg_valid), 2'b00);
      id_rs_data[31:0] = 32'h3333_3333;
      issue(0, 0, 0, 3, 4);
      chk("t5_rf_x3", op_data[31:0], 32'h3333_3333);
      chk("t5_rf_x4", op_data[63:32], 32'h2222_2222);
      drain();
      // 6: mem_wait during load-use, then reset mid-stall
      issue(1, 7, 1, 0, 0); tick();
      issue(1, 8, 0, 7, 0);
      mem_wait = 1; #1;
      for (int i = 0; i < 3; i++) begin
         chk("t6_stall_frozen", 32'(stall), 1);
         tick();
         chk("t6_valid_frozen", 32'(stg_valid), 2'b01);
      end
      chk("t6_count", stall_count, 4);
      mem_wait = 0; #1;
      chk("t6_hazard_remains", 32'(stall), 1);
      rst = 1; #1;
      chk("t6_rst_valid", 32'(stg_valid), 0);
      chk("t6_rst_stall", 32'(stall), 0);
      chk("t6_rst_count", stall_count, 0);
      tick();
      rst = 0;
      tick();
      chk("t6_post_rst_count", stall_count, 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end
endmodule
